// File: rtl/m_imem_loader_pkg.sv
// Shared types and defaults for the IMEM program loader: FSM state encoding,
// default geometry and the little-endian word packing helper.
package m_imem_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam int ADDR_W_DEF     = 10;
  localparam int IMEM_WORDS_DEF = 1024;
  localparam int CNT_W          = 16;

  // Bytes arrive LSB first, so the newest byte lands in the top lane.
  function automatic logic [31:0] pack_word(input logic [7:0] top_byte,
                                            input logic [23:0] low_bytes);
    return {top_byte, low_bytes};
  endfunction

endpackage

// File: rtl/m_imem_loader_byte_pack.sv
// Byte-to-word assembler: 2-bit lane counter plus a 24-bit holding register.
// The word is presented combinationally in the same cycle its 4th byte is pushed.
module m_byte_pack
  import m_imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  lane_q;
  logic [23:0] low_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      lane_q <= 2'd0;
    end else if (push_i) begin
      lane_q <= lane_q + 2'd1;
    end
  end

  // Holding register is overwritten by every full word, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      low_q <= {byte_i, low_q[23:8]};
    end
  end

  assign word_o       = pack_word(byte_i, low_q);
  assign word_valid_o = push_i && (lane_q == 2'd3);

endmodule

// File: rtl/m_imem_loader.sv
// Length-prefixed byte-stream loader for the m_proc4 instruction memory.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_in_valid,
  input  logic [7:0]        w_in_data,
  output logic              w_in_ready,
  output logic              w_mem_we,
  output logic [ADDR_W-1:0] w_mem_addr,
  output logic [31:0]       w_mem_wdata,
  output logic              w_core_rst,
  output logic              w_done,
  output logic              w_err
);

  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(IMEM_WORDS);

  state_e             state_q;
  logic [CNT_W-1:0]   n_q;
  logic [CNT_W-1:0]   word_cnt_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic               done_q;
  logic               err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  logic               accept;
  logic               push;
  logic [CNT_W-1:0]   n_full;
  logic [31:0]        word;
  logic               word_valid;

  assign w_in_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                      (state_q == S_DATA) || (state_q == S_CHK);
  assign accept     = w_in_valid && w_in_ready;
  assign push       = accept && (state_q == S_DATA);
  assign n_full     = {w_in_data, n_q[7:0]};

  // Any state outside S_DATA discards a partial word.
  m_byte_pack u_pack (
    .clk_i        (w_clk),
    .rst_i        (w_rst),
    .clear_i      (state_q != S_DATA),
    .push_i       (push),
    .byte_i       (w_in_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q    <= S_HDR0;
      n_q        <= '0;
      word_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_HDR0: begin
          if (accept) begin
            n_q[7:0] <= w_in_data;
            state_q  <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (accept) begin
            n_q        <= n_full;
            word_cnt_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
            if ({1'b0, n_full} > MAX_WORDS) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else if (n_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q <= S_CHK;
`else
              state_q <= S_DONE;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (push) begin
            csum_q <= csum_q ^ w_in_data;
          end
`endif
          if (word_valid) begin
            we_q       <= 1'b1;
            addr_q     <= word_cnt_q[ADDR_W-1:0];
            wdata_q    <= word;
            word_cnt_q <= word_cnt_q + 1'b1;
            if (word_cnt_q == n_q - 1'b1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q <= S_CHK;
`else
              state_q <= S_DONE;
`endif
            end
          end
        end
        S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) begin
            if (w_in_data == csum_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
`endif
        end
        // Done trails the final write by one cycle so the core never sees a half-written image.
        S_DONE: done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign w_mem_we    = we_q;
  assign w_mem_addr  = addr_q;
  assign w_mem_wdata = wdata_q;
  assign w_done      = done_q;
  assign w_err       = err_q;
  assign w_core_rst  = ~done_q;

endmodule
